// File: rtl/rvvi_trace_pkg.sv
//==============================================================================
// Module      : rvvi_trace_pkg
// Description : Shared types for the RVVI retirement queue. It holds the
//               stored retirement record and the helper that builds the
//               one-hot register-write mask.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package rvvi_trace_pkg;

    // Retirement sequence number width
    localparam int ORDER_W  = 64;
    // Records always store full 64-bit PC/data; XLEN=32 builds zero-extend
    localparam int REC_XLEN = 64;

    typedef struct packed {
        logic [ORDER_W-1:0]  order;
        logic [31:0]         insn;
        logic [REC_XLEN-1:0] pc;
        logic                trap;
        logic [1:0]          mode;
        logic [31:0]         x_wb;
        logic [REC_XLEN-1:0] x_wdata;
    } retire_rec_t;

    // One-hot integer write mask; writes to x0 are architecturally invisible
    function automatic logic [31:0] xwb_mask(input logic [4:0] rd, input logic we);
        logic [31:0] m;
        m = 32'd0;
        if (we && (rd != 5'd0)) begin
            m = 32'd1 << rd;
        end
        return m;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rvvi_retire_queue_if.sv
//==============================================================================
// Module      : rvvi_retire_queue_if
// Description : Retire-port / RVVI-record bundle for rvvi_retire_queue.
//               slave = queue side, master = core + consumer side.
//               Optional stats signals exist when RVVI_RETIRE_Q_STATS_EN
//               is defined.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface rvvi_retire_queue_if
    import rvvi_trace_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int DEPTH = 8
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // Retire port (never stalled)
    logic               in_valid;
    logic [31:0]        in_insn;
    logic [XLEN-1:0]    in_pc;
    logic               in_trap;
    logic [1:0]         in_mode;
    logic [4:0]         in_rd;
    logic               in_rd_we;
    logic [XLEN-1:0]    in_rd_data;

    // RVVI record port
    logic               out_valid;
    logic               out_ready;
    logic [ORDER_W-1:0] out_order;
    logic [31:0]        out_insn;
    logic [XLEN-1:0]    out_pc;
    logic               out_trap;
    logic [1:0]         out_mode;
    logic [31:0]        out_x_wb;
    logic [XLEN-1:0]    out_x_wdata;

    // Status
    logic [CNT_W-1:0]   count;
    logic               overflow;
    logic               overflow_clr;
`ifdef RVVI_RETIRE_Q_STATS_EN
    logic [CNT_W-1:0]   hwm;
    logic [31:0]        drop_cnt;
`endif

    modport slave (
        input  in_valid, in_insn, in_pc, in_trap, in_mode, in_rd, in_rd_we, in_rd_data,
        input  out_ready, overflow_clr,
        output out_valid, out_order, out_insn, out_pc, out_trap, out_mode,
        output out_x_wb, out_x_wdata, count,
        output overflow
`ifdef RVVI_RETIRE_Q_STATS_EN
        ,
        output hwm,
        output drop_cnt
`endif
    );

    modport master (
        output in_valid, in_insn, in_pc, in_trap, in_mode, in_rd, in_rd_we, in_rd_data,
        output out_ready, overflow_clr,
        input  out_valid, out_order, out_insn, out_pc, out_trap, out_mode,
        input  out_x_wb, out_x_wdata, count,
        input  overflow
`ifdef RVVI_RETIRE_Q_STATS_EN
        ,
        input  hwm,
        input  drop_cnt
`endif
    );

endinterface

`default_nettype wire

// File: rtl/rvvi_fifo_mem.sv
//==============================================================================
// Module      : rvvi_fifo_mem
// Description : DEPTH x retire_rec_t register array, one synchronous write
//               port and one asynchronous read port. Pure storage; pointer
//               and occupancy control live in the parent.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module rvvi_fifo_mem
    import rvvi_trace_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  wire logic        clk,
    input  wire logic        i_we,
    input  wire logic [AW-1:0] i_waddr,
    input  wire retire_rec_t i_wdata,
    input  wire logic [AW-1:0] i_raddr,
    output retire_rec_t      o_rdata
);

    retire_rec_t r_mem [DEPTH];

    // Storage write; no reset needed since reads are gated by occupancy
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/rvvi_retire_queue.sv
//==============================================================================
// Module      : rvvi_retire_queue
// Description : First-word-fall-through queue that turns per-cycle core
//               retirements into in-order RVVI records for a back-pressuring
//               consumer. Retirements arriving on a full queue with no pop
//               are dropped and flagged in a sticky overflow bit.
//               Optional macro RVVI_RETIRE_Q_STATS_EN adds hwm / drop_cnt.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module rvvi_retire_queue
    import rvvi_trace_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int DEPTH = 8
) (
    input  wire logic          clk,
    input  wire logic          reset,
    rvvi_retire_queue_if.slave bus
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;
    localparam logic [CNT_W-1:0] c_depth_cnt = CNT_W'(DEPTH);

    logic [AW-1:0]      r_head;
    logic [AW-1:0]      r_tail;
    logic [CNT_W-1:0]   r_count;
    logic [ORDER_W-1:0] r_order;
    logic               r_overflow;

    logic               w_out_valid;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic [CNT_W-1:0]   w_count_nxt;
    logic [31:0]        w_x_wb;
    retire_rec_t        w_wr_rec;
    retire_rec_t        w_head_rec;

    // A full queue still accepts when the head leaves in the same cycle
    assign w_out_valid = (r_count != '0);
    assign w_pop       = w_out_valid & bus.out_ready;
    assign w_push      = bus.in_valid & ((r_count < c_depth_cnt) | w_pop);
    assign w_drop      = bus.in_valid & ~w_push;
    assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

    // Build the record to store, tagging it with the current order number
    always_comb begin
        w_x_wb           = xwb_mask(bus.in_rd, bus.in_rd_we);
        w_wr_rec         = '0;
        w_wr_rec.order   = r_order;
        w_wr_rec.insn    = bus.in_insn;
        w_wr_rec.pc      = REC_XLEN'(bus.in_pc);
        w_wr_rec.trap    = bus.in_trap;
        w_wr_rec.mode    = bus.in_mode;
        w_wr_rec.x_wb    = w_x_wb;
        w_wr_rec.x_wdata = (w_x_wb != 32'd0) ? REC_XLEN'(bus.in_rd_data) : '0;
    end

    rvvi_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_tail),
        .i_wdata (w_wr_rec),
        .i_raddr (r_head),
        .o_rdata (w_head_rec)
    );

    // Pointers, occupancy and order counter; order only advances on accept
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_order <= ORDER_W'(1);
        end else begin
            if (w_push) begin
                r_tail  <= r_tail + AW'(1);
                r_order <= r_order + ORDER_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + AW'(1);
            end
            r_count <= w_count_nxt;
        end
    end

    // Sticky overflow; a same-cycle drop beats the clear request
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (bus.overflow_clr) begin
            r_overflow <= 1'b0;
        end
    end

    // Record fields read as zero whenever no record is presented
    assign bus.out_valid   = w_out_valid;
    assign bus.out_order   = w_out_valid ? w_head_rec.order : '0;
    assign bus.out_insn    = w_out_valid ? w_head_rec.insn : '0;
    assign bus.out_pc      = w_out_valid ? w_head_rec.pc[XLEN-1:0] : '0;
    assign bus.out_trap    = w_out_valid ? w_head_rec.trap : 1'b0;
    assign bus.out_mode    = w_out_valid ? w_head_rec.mode : 2'b00;
    assign bus.out_x_wb    = w_out_valid ? w_head_rec.x_wb : '0;
    assign bus.out_x_wdata = w_out_valid ? w_head_rec.x_wdata[XLEN-1:0] : '0;
    assign bus.count       = r_count;
    assign bus.overflow    = r_overflow;

`ifdef RVVI_RETIRE_Q_STATS_EN
    logic [CNT_W-1:0] r_hwm;
    logic [31:0]      r_drop_cnt;

    // High-water mark of occupancy and saturating dropped-retire counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hwm      <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_count_nxt > r_hwm) begin
                r_hwm <= w_count_nxt;
            end
            if (w_drop && (r_drop_cnt != '1)) begin
                r_drop_cnt <= r_drop_cnt + 32'd1;
            end
        end
    end

    assign bus.hwm      = r_hwm;
    assign bus.drop_cnt = r_drop_cnt;
`else
    // Statistics counters are not built in this configuration
`endif

endmodule

`default_nettype wire

// File: tb/tb_rvvi_retire_queue.sv
//==============================================================================
// Module      : tb_rvvi_retire_queue
// Description : Self-checking bench for rvvi_retire_queue. Directed steps
//               followed by random traffic, compared every cycle against a
//               queue-based reference model. Stats checks are compiled in
//               when RVVI_RETIRE_Q_STATS_EN is defined.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_rvvi_retire_queue;

    localparam int XLEN  = 64;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    rvvi_retire_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

    rvvi_retire_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [63:0] order;
        logic [31:0] insn;
        logic [63:0] pc;
        logic        trap;
        logic [1:0]  mode;
        logic [31:0] xwb;
        logic [63:0] xwdata;
    } exp_rec_t;

    exp_rec_t    mq[$];
    logic [63:0] m_order;
    bit          m_ovf;
    int          m_hwm;
    int unsigned m_drops;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_order = 64'd1;
        m_ovf   = 1'b0;
        m_hwm   = 0;
        m_drops = 0;
    endtask

    task automatic check_all();
        exp_rec_t h;
        bit ne;
        ne = (mq.size() != 0);
        h  = '{order: 64'd0, insn: 32'd0, pc: 64'd0, trap: 1'b0, mode: 2'd0, xwb: 32'd0, xwdata: 64'd0};
        if (ne) h = mq[0];
        chk("out_valid",   bus.out_valid,   ne);
        chk("count",       bus.count,       mq.size());
        chk("overflow",    bus.overflow,    m_ovf);
        chk("out_order",   bus.out_order,   h.order);
        chk("out_insn",    bus.out_insn,    h.insn);
        chk("out_pc",      bus.out_pc,      h.pc);
        chk("out_trap",    bus.out_trap,    h.trap);
        chk("out_mode",    bus.out_mode,    h.mode);
        chk("out_x_wb",    bus.out_x_wb,    h.xwb);
        chk("out_x_wdata", bus.out_x_wdata, h.xwdata);
`ifdef RVVI_RETIRE_Q_STATS_EN
        chk("hwm",         bus.hwm,         m_hwm);
        chk("drop_cnt",    bus.drop_cnt,    m_drops);
`endif
    endtask

    // Drive one cycle of inputs, advance the model across the edge, check at negedge
    task automatic drive(input bit v, input logic [31:0] insn, input logic [63:0] pc,
                         input bit trap, input logic [1:0] mode, input logic [4:0] rd,
                         input bit we, input logic [63:0] data, input bit rdy, input bit clr);
        bit pop, push, drop;
        exp_rec_t r;
        bus.in_valid     = v;
        bus.in_insn      = insn;
        bus.in_pc        = pc;
        bus.in_trap      = trap;
        bus.in_mode      = mode;
        bus.in_rd        = rd;
        bus.in_rd_we     = we;
        bus.in_rd_data   = data;
        bus.out_ready    = rdy;
        bus.overflow_clr = clr;
        pop  = (mq.size() > 0) && rdy;
        push = v && ((mq.size() < DEPTH) || pop);
        drop = v && !push;
        r.order = m_order;
        r.insn  = insn;
        r.pc    = pc;
        r.trap  = trap;
        r.mode  = mode;
        r.xwb   = 32'd0;
        for (int i = 1; i < 32; i++) r.xwb[i] = we && (rd == i[4:0]);
        r.xwdata = (r.xwb != 32'd0) ? data : 64'd0;
        @(posedge clk);
        if (pop) void'(mq.pop_front());
        if (push) begin
            mq.push_back(r);
            m_order = m_order + 64'd1;
        end
        if (drop) begin
            m_ovf = 1'b1;
            if (m_drops != 32'hFFFF_FFFF) m_drops++;
        end else if (clr) begin
            m_ovf = 1'b0;
        end
        if (mq.size() > m_hwm) m_hwm = mq.size();
        @(negedge clk);
        check_all();
    endtask

    task automatic retire(input logic [63:0] pc, input bit rdy, input bit clr);
        drive(1'b1, $urandom, pc, 1'($urandom), 2'($urandom), 5'($urandom), 1'($urandom),
              {$urandom, $urandom}, rdy, clr);
    endtask

    task automatic idle(input bit rdy, input bit clr);
        drive(1'b0, 32'd0, 64'd0, 1'b0, 2'd0, 5'd0, 1'b0, 64'd0, rdy, clr);
    endtask

    initial begin
        reset            = 1'b1;
        bus.in_valid     = 1'b0;
        bus.in_insn      = '0;
        bus.in_pc        = '0;
        bus.in_trap      = 1'b0;
        bus.in_mode      = '0;
        bus.in_rd        = '0;
        bus.in_rd_we     = 1'b0;
        bus.in_rd_data   = '0;
        bus.out_ready    = 1'b0;
        bus.overflow_clr = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_all();

        // Step 1: three back-to-back retires with a ready consumer
        retire(64'h8000_0000, 1'b1, 1'b0);
        chk("t1_order1", bus.out_order, 64'd1);
        chk("t1_pc1",    bus.out_pc,    64'h8000_0000);
        retire(64'h8000_0004, 1'b1, 1'b0);
        chk("t1_order2", bus.out_order, 64'd2);
        retire(64'h8000_0008, 1'b1, 1'b0);
        chk("t1_order3", bus.out_order, 64'd3);
        chk("t1_pc3",    bus.out_pc,    64'h8000_0008);
        idle(1'b1, 1'b0);
        chk("t1_empty",  bus.out_valid, 1'b0);

        // Step 2: stalled consumer, DEPTH+2 retires, then set-beats-clear, then drain
        for (int i = 0; i < DEPTH + 2; i++) retire(64'h1000 + 64'(4 * i), 1'b0, 1'b0);
        chk("t2_count_full", bus.count, DEPTH);
        chk("t2_overflow",   bus.overflow, 1'b1);
        retire(64'h2000, 1'b0, 1'b1);
        chk("t2_set_wins",   bus.overflow, 1'b1);
        for (int i = 0; i < DEPTH; i++) begin
            chk("t2_drain_order", bus.out_order, 64'(4 + i));
            idle(1'b1, 1'b0);
        end
        retire(64'h3000, 1'b0, 1'b0);
        chk("t2_next_order", bus.out_order, 64'(4 + DEPTH));
        idle(1'b1, 1'b0);

        // Step 3: full queue with simultaneous pop accepts without dropping
        idle(1'b0, 1'b1);
        chk("t3_ovf_cleared", bus.overflow, 1'b0);
        for (int i = 0; i < DEPTH; i++) retire(64'h4000 + 64'(4 * i), 1'b0, 1'b0);
        retire(64'h5000, 1'b1, 1'b0);
        chk("t3_count",    bus.count,    DEPTH);
        chk("t3_overflow", bus.overflow, 1'b0);
        for (int i = 0; i < DEPTH; i++) idle(1'b1, 1'b0);

        // Step 4: x0 write is masked, x5 write is visible
        drive(1'b1, 32'h0000_0013, 64'h6000, 1'b0, 2'd3, 5'd0, 1'b1, 64'hdead, 1'b0, 1'b0);
        chk("t4_x0_wb",    bus.out_x_wb,    32'd0);
        chk("t4_x0_wdata", bus.out_x_wdata, 64'd0);
        drive(1'b1, 32'h0000_0293, 64'h6004, 1'b1, 2'd1, 5'd5, 1'b1, 64'h1234, 1'b1, 1'b0);
        chk("t4_x5_wb",    bus.out_x_wb,    32'h20);
        chk("t4_x5_wdata", bus.out_x_wdata, 64'h1234);
        chk("t4_trap",     bus.out_trap,    1'b1);
        idle(1'b1, 1'b0);

        // Step 5: asynchronous reset with entries queued
        for (int i = 0; i < 4; i++) retire(64'h7000 + 64'(4 * i), 1'b0, 1'b0);
        idle(1'b0, 1'b0);
        reset = 1'b1;
        #1;
        chk("t5_valid_in_reset", bus.out_valid, 1'b0);
        chk("t5_count_in_reset", bus.count,     0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        check_all();
        retire(64'h8000_0000, 1'b0, 1'b0);
        chk("t5_order_after_reset", bus.out_order, 64'd1);
        idle(1'b1, 1'b0);

`ifdef RVVI_RETIRE_Q_STATS_EN
        // Step 6: two drops then clear
        for (int i = 0; i < DEPTH + 2; i++) retire(64'h9000 + 64'(4 * i), 1'b0, 1'b0);
        idle(1'b0, 1'b1);
        chk("t6_drop_cnt", bus.drop_cnt, 32'd2);
        chk("t6_overflow", bus.overflow, 1'b0);
        chk("t6_hwm",      bus.hwm,      DEPTH);
        for (int i = 0; i < DEPTH; i++) idle(1'b1, 1'b0);
`endif

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(99) < 70)
                retire({$urandom, $urandom}, ($urandom_range(99) < 45), ($urandom_range(99) < 5));
            else
                idle(($urandom_range(99) < 60), ($urandom_range(99) < 5));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
